// File: rtl/multicycle_cond_logic_if.sv
// Control bundle between the multicycle decoder/FSM and the conditional-execution logic.
// The slave side is the conditional logic; the master side drives the raw controls.
interface multicycle_cond_logic_if;
    logic [3:0]  Cond;
    logic [3:0]  ALUFlags;
    logic [1:0]  FlagW;
    logic        PCS;
    logic        RegW;
    logic        MemW;
    logic        NextPC;
    logic        NoWrite;
    logic        IRWrite;
    logic        PCWrite;
    logic        RegWrite;
    logic        MemWrite;
    logic [3:0]  Flags;
    logic        CondEx;
    logic [15:0] ExecCnt;
    logic [15:0] SkipCnt;

    modport master (
        output Cond, ALUFlags, FlagW, PCS, RegW, MemW, NextPC, NoWrite, IRWrite,
        input  PCWrite, RegWrite, MemWrite, Flags, CondEx, ExecCnt, SkipCnt
    );

    modport slave (
        input  Cond, ALUFlags, FlagW, PCS, RegW, MemW, NextPC, NoWrite, IRWrite,
        output PCWrite, RegWrite, MemWrite, Flags, CondEx, ExecCnt, SkipCnt
    );
endinterface

// File: rtl/multicycle_cond_logic.sv
// ARM-style conditional execution for a multicycle core: latches the condition result once
// per decoded instruction, gates the write enables, and counts executed/skipped instructions.
module multicycle_cond_logic (
    input logic                  clk,
    input logic                  Reset,
    multicycle_cond_logic_if.slave bus
);
    logic        decode_valid_q;
    logic        cond_ex_q,  cond_ex_d;
    logic [3:0]  flags_q,    flags_d;
    logic [15:0] exec_cnt_q, exec_cnt_d;
    logic [15:0] skip_cnt_q, skip_cnt_d;
    logic        cond_pass;
    logic        flag_n, flag_z, flag_c, flag_v;

    assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

    // Uses the architectural flags, so a flag write in the decode cycle is not yet visible.
    always_comb begin
        cond_pass = 1'b1;
        unique case (bus.Cond)
            4'b0000: cond_pass = flag_z;
            4'b0001: cond_pass = !flag_z;
            4'b0010: cond_pass = flag_c;
            4'b0011: cond_pass = !flag_c;
            4'b0100: cond_pass = flag_n;
            4'b0101: cond_pass = !flag_n;
            4'b0110: cond_pass = flag_v;
            4'b0111: cond_pass = !flag_v;
            4'b1000: cond_pass = flag_c && !flag_z;
            4'b1001: cond_pass = !flag_c || flag_z;
            4'b1010: cond_pass = (flag_n == flag_v);
            4'b1011: cond_pass = (flag_n != flag_v);
            4'b1100: cond_pass = !flag_z && (flag_n == flag_v);
            4'b1101: cond_pass = flag_z || (flag_n != flag_v);
            4'b1110: cond_pass = 1'b1;
            4'b1111: cond_pass = 1'b1;
        endcase
    end

    always_comb begin
        cond_ex_d  = cond_ex_q;
        exec_cnt_d = exec_cnt_q;
        skip_cnt_d = skip_cnt_q;
        flags_d    = flags_q;

        if (decode_valid_q) begin
            cond_ex_d = cond_pass;
            if (cond_pass) begin
                if (exec_cnt_q != 16'hFFFF) exec_cnt_d = exec_cnt_q + 16'd1;
            end else begin
                if (skip_cnt_q != 16'hFFFF) skip_cnt_d = skip_cnt_q + 16'd1;
            end
        end

        // Flag writes are gated by the currently latched CondEx, not the new decode result.
        if (bus.FlagW[1] && cond_ex_q) flags_d[3:2] = bus.ALUFlags[3:2];
        if (bus.FlagW[0] && cond_ex_q) flags_d[1:0] = bus.ALUFlags[1:0];
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            decode_valid_q <= 1'b0;
            cond_ex_q      <= 1'b0;
            flags_q        <= 4'b0000;
            exec_cnt_q     <= 16'd0;
            skip_cnt_q     <= 16'd0;
        end else begin
            decode_valid_q <= bus.IRWrite;
            cond_ex_q      <= cond_ex_d;
            flags_q        <= flags_d;
            exec_cnt_q     <= exec_cnt_d;
            skip_cnt_q     <= skip_cnt_d;
        end
    end

    assign bus.PCWrite  = (bus.PCS && cond_ex_q) || bus.NextPC;
    assign bus.RegWrite = bus.RegW && cond_ex_q && !bus.NoWrite;
    assign bus.MemWrite = bus.MemW && cond_ex_q;
    assign bus.Flags    = flags_q;
    assign bus.CondEx   = cond_ex_q;
    assign bus.ExecCnt  = exec_cnt_q;
    assign bus.SkipCnt  = skip_cnt_q;
endmodule
